// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the EX-stage multiply/divide unit.
package riscv_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned HALF  = XLEN / 2;
  localparam int unsigned CNT_W = 7;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  // func3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_e;

  // MUL is treated as signed so word multiplies keep magnitudes within 32 bits;
  // the low product half is identical either way.
  function automatic logic rs1_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider.
module muldiv_step
  import riscv_pkg::*;
(
  input  logic            div_mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_next_c,
  output logic [XLEN-1:0] lo_next_c
);

  logic [XLEN:0] sum_c;
  logic [XLEN:0] shifted_c;
  logic          ge_c;

  // Multiply: add multiplicand on lo[0], shift {carry,hi,lo} right.
  // Divide: shift {hi,lo} left, trial-subtract divisor, shift in quotient bit.
  always_comb begin
    sum_c     = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
    shifted_c = {hi, lo[XLEN-1]};
    ge_c      = shifted_c >= {1'b0, b};
    hi_next_c = sum_c[XLEN:1];
    lo_next_c = {sum_c[0], lo[XLEN-1:1]};
    if (div_mode) begin
      if (ge_c) begin
        hi_next_c = shifted_c[XLEN-1:0] - b;
        lo_next_c = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next_c = shifted_c[XLEN-1:0];
        lo_next_c = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit in EX; stalls the front end while busy.
// Optional MULDIV_WORD_EN adds the is_word input for the *W instructions.
module ex_muldiv_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
`ifdef MULDIV_WORD_EN
  input  logic            is_word,
`endif
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q;
  muldiv_op_e      op_in_c;
  logic            word_q, word_in_c;
  logic [XLEN-1:0] a_q, b_q, b_mag_q, hi_q, lo_q, result_q;
  logic            a_neg_q, b_neg_q;
  logic [CNT_W-1:0] count_q;

  logic [XLEN-1:0] a_in_c, b_in_c;
  logic            accept_c, last_iter_c, is_div_c;
  logic            a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_abs_c, b_abs_c;
  logic [XLEN-1:0] hi_step_c, lo_step_c;
  logic [2*XLEN-1:0] prod_raw_c, prod_c;
  logic [XLEN-1:0] quot_c, rem_c, min_c, fix_c;

`ifdef MULDIV_WORD_EN
  assign word_in_c = is_word;
`else
  assign word_in_c = 1'b0;
`endif

  assign op_in_c     = muldiv_op_e'(op);
  assign accept_c    = (state_q == IDLE) && start && !flush;
  assign is_div_c    = op_q[2];
  assign last_iter_c = count_q == (word_q ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1));

  // Operand capture value: word ops use the low half, sign- or zero-extended
  always_comb begin
    a_in_c = rs1_val;
    b_in_c = rs2_val;
    if (word_in_c) begin
      a_in_c = rs1_signed(op_in_c) ? {{HALF{rs1_val[HALF-1]}}, rs1_val[HALF-1:0]}
                                   : {{HALF{1'b0}}, rs1_val[HALF-1:0]};
      b_in_c = rs2_signed(op_in_c) ? {{HALF{rs2_val[HALF-1]}}, rs2_val[HALF-1:0]}
                                   : {{HALF{1'b0}}, rs2_val[HALF-1:0]};
    end
  end

  // Operand magnitudes and sign flags for the unsigned core
  always_comb begin
    a_neg_c = rs1_signed(op_q) & a_q[XLEN-1];
    b_neg_c = rs2_signed(op_q) & b_q[XLEN-1];
    a_abs_c = a_neg_c ? -a_q : a_q;
    b_abs_c = b_neg_c ? -b_q : b_q;
  end

  muldiv_step u_step (
    .div_mode  (is_div_c),
    .hi        (hi_q),
    .lo        (lo_q),
    .b         (b_mag_q),
    .hi_next_c (hi_step_c),
    .lo_next_c (lo_step_c)
  );

  // Sign correction, special cases and result selection
  always_comb begin
    prod_raw_c = word_q ? ({hi_q, lo_q} >> HALF) : {hi_q, lo_q};
    prod_c     = (a_neg_q ^ b_neg_q) ? -prod_raw_c : prod_raw_c;
    quot_c     = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
    rem_c      = a_neg_q ? -hi_q : hi_q;
    min_c      = word_q ? {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}}
                        : {1'b1, {(XLEN-1){1'b0}}};
    if (b_q == '0) begin
      quot_c = '1;
      rem_c  = a_q;
    end else if (rs1_signed(op_q) && (a_q == min_c) && (b_q == '1)) begin
      quot_c = min_c;
      rem_c  = '0;
    end
    case (op_q)
      OP_MUL:                        fix_c = prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_c = prod_c[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_c = quot_c;
      default:                       fix_c = rem_c;
    endcase
    if (word_q) fix_c = {{HALF{fix_c[HALF-1]}}, fix_c[HALF-1:0]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and pipeline stall request
  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d   = PREP;
          stall_req = 1'b1;
        end
      end
      PREP: begin
        state_d   = CALC;
        stall_req = 1'b1;
      end
      CALC: begin
        if (last_iter_c) state_d = FIX;
        stall_req = 1'b1;
      end
      FIX: begin
        state_d   = DONE;
        stall_req = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      word_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      b_mag_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            op_q   <= op_in_c;
            word_q <= word_in_c;
            a_q    <= a_in_c;
            b_q    <= b_in_c;
          end
        end
        PREP: begin
          a_neg_q <= a_neg_c;
          b_neg_q <= b_neg_c;
          b_mag_q <= b_abs_c;
          hi_q    <= '0;
          lo_q    <= (is_div_c && word_q) ? {a_abs_c[HALF-1:0], {HALF{1'b0}}} : a_abs_c;
          count_q <= '0;
        end
        CALC: begin
          hi_q    <= hi_step_c;
          lo_q    <= lo_step_c;
          count_q <= count_q + CNT_W'(1);
        end
        FIX: begin
          if (!flush) result_q <= fix_c;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (default 64-bit build).
module tb_ex_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [63:0] rs1_val, rs2_val;
  logic        busy, stall_req, done;
  logic [63:0] result;
`ifdef MULDIV_WORD_EN
  logic        is_word = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
`ifdef MULDIV_WORD_EN
    .is_word   (is_word),
`endif
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, check latency/stall/result
  task automatic run_op(input string tag, input logic [2:0] op_v, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input bit inject);
    int cyc;
    int stall_lo;
    bit seen;
    op = op_v; rs1_val = a; rs2_val = b; start = 1'b1;
    #1 check_eq({tag, "_stall_accept"}, 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; op = ~op_v; rs1_val = ~a; rs2_val = ~b;
    check_eq({tag, "_busy_prep"}, 64'(busy), 64'd1);
    cyc = 0; stall_lo = 0; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      if (!stall_req) stall_lo++;
      if (inject && cyc == 5) begin
        start = 1'b1; op = 3'b000; rs1_val = 64'd3; rs2_val = 64'd4;
      end
      if (inject && cyc == 6) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'd66);
    check_eq({tag, "_result"}, result, exp);
    check_eq({tag, "_stall_done"}, 64'(stall_req), 64'd0);
    check_eq({tag, "_stall_gaps"}, 64'(stall_lo), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Count done pulses over a window where none may appear
  task automatic quiet_window(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) hits++;
    end
    check_eq(tag, 64'(hits), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000;
    rs1_val = '0; rs2_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",   64'(busy),      64'd0);
    check_eq("rst_stall",  64'(stall_req), 64'd0);
    check_eq("rst_done",   64'(done),      64'd0);
    check_eq("rst_result", result,         64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7_m3",   3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("mulhu_ones", 3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("mulh_ones",  3'b001, '1, '1, 64'd0, 1'b0);
    run_op("mulhsu_m1",  3'b010, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("mul_2p64",   3'b000, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b0);
    run_op("mulhu_2p64", 3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 1'b0);
    run_op("div_m20_3",  3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    run_op("rem_m20_3",  3'b110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("divu_100_7", 3'b101, 64'd100, 64'd7, 64'd14, 1'b0);
    run_op("remu_100_7", 3'b111, 64'd100, 64'd7, 64'd2, 1'b0);
    run_op("divu_5_0",   3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("remu_5_0",   3'b111, 64'd5, 64'd0, 64'd5, 1'b0);
    run_op("div_m5_0",   3'b100, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("rem_m5_0",   3'b110, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    run_op("div_ovf",    3'b100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b0);
    run_op("rem_ovf",    3'b110, 64'h8000_0000_0000_0000, '1, 64'd0, 1'b0);
    run_op("mulhu_seed", 3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 1'b0);

    // Flush on the 10th CALC edge (E11): back to IDLE, no done, result kept
    op = 3'b000; rs1_val = 64'd5; rs2_val = 64'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    check_eq("flush_stall_calc", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy",   64'(busy),      64'd0);
    check_eq("flush_done",   64'(done),      64'd0);
    check_eq("flush_stall",  64'(stall_req), 64'd0);
    check_eq("flush_result", result,         64'd1);
    quiet_window("flush_no_done", 70);
    check_eq("flush_result_hold", result, 64'd1);
    run_op("mul_3_4", 3'b000, 64'd3, 64'd4, 64'd12, 1'b0);

    // Reset mid-CALC clears everything and produces no done
    op = 3'b101; rs1_val = 64'd100; rs2_val = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rstmid_busy",   64'(busy),      64'd0);
    check_eq("rstmid_stall",  64'(stall_req), 64'd0);
    check_eq("rstmid_done",   64'(done),      64'd0);
    check_eq("rstmid_result", result,         64'd0);
    rst_n = 1'b1;
    quiet_window("rstmid_no_done", 70);

    // A start while busy is ignored; the original op completes
    run_op("busy_start_ignored", 3'b101, 64'd100, 64'd7, 64'd14, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
